lcd_frame_sequencer: RTL and testbench

- Upstream feeder for the LCD instruction path: holds a 2x16 character frame buffer, written by user logic.
- Once LCD power-on initialisation completes, streams the frame to the instruction FSM as a sequence of 10-bit db words {RS, RW, D7..D0}.
- Frame sequence: set-DDRAM-address 0x80, 16 chars, set-DDRAM-address 0xC0, 16 chars; then waits a refresh period and repeats.
- Drives the same next_instruction/done handshake the instruction FSM consumes.

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_frame_buffer.sv | 30 +++
 rtl/lcd_frame_sequencer.sv | 155 +++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame sequencer: state encoding,
// DDRAM address commands and the frame step -> db word mapping.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_REFRESH   = 2'd3
    } lcd_state_e;

    localparam logic [7:0] LINE1_ADDR_CMD = 8'h80;
    localparam logic [7:0] LINE2_ADDR_CMD = 8'hC0;
    localparam int         CHARS_PER_LINE = 16;
    localparam int         FRAME_STEPS    = 34;
    localparam logic [7:0] SPACE_CHAR     = 8'h20;
    localparam int         BUF_DEPTH      = 2 * CHARS_PER_LINE;
    localparam logic [5:0] LINE2_STEP     = 6'(CHARS_PER_LINE + 1);
    localparam logic [5:0] LAST_STEP      = 6'(FRAME_STEPS - 1);

    // Buffer index read at a given step; idx 0 and LINE2_STEP read a don't-care entry.
    function automatic logic [4:0] step_char_addr(input logic [5:0] idx);
        logic [5:0] a;
        if (idx <= LINE2_STEP) begin
            a = idx - 6'd1;
        end else begin
            a = idx - 6'd2;
        end
        return a[4:0];
    endfunction

    function automatic logic [9:0] step_word(input logic [5:0] idx, input logic [7:0] ch);
        logic [9:0] w;
        if (idx == 6'd0) begin
            w = {2'b00, LINE1_ADDR_CMD};
        end else if (idx == LINE2_STEP) begin
            w = {2'b00, LINE2_ADDR_CMD};
        end else begin
            w = {2'b10, ch};
        end
        return w;
    endfunction

endpackage

// File: rtl/lcd_frame_buffer.sv
// 2x16 character frame buffer: synchronous write, combinational read,
// asynchronously reset to spaces.
module lcd_frame_buffer
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem_r [BUF_DEPTH];

    // Character storage; writes accepted at any time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= SPACE_CHAR;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Streams the 2x16 frame buffer to the LCD instruction FSM, one frame per refresh
// period. Define LCD_FRAME_DIRTY_EN to only resend a frame after a buffer write.
module lcd_frame_sequencer
    import lcd_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50000000,
    parameter int CNT_W          = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       done,
    output logic [9:0] db,
    output logic       next_instruction,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);

    lcd_state_e       state_r, state_n;
    logic [5:0]       idx_r, idx_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [9:0]       db_r, db_n;
    logic             ni_r, ni_n;
    logic             busy_r, busy_n;
    logic             fd_r, fd_n;
    logic [4:0]       rd_addr_s;
    logic [7:0]       rd_data_s;
    logic             start_ok_s;

    assign rd_addr_s = step_char_addr(idx_r);

    lcd_frame_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

`ifdef LCD_FRAME_DIRTY_EN
    logic dirty_r;

    // Dirty flag: starts set so the first frame after init always goes out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty_r <= 1'b1;
        end else if (wr_en) begin
            dirty_r <= 1'b1;
        end else if (state_r == ST_ISSUE && idx_r == 6'd0) begin
            dirty_r <= 1'b0;
        end else begin
            dirty_r <= dirty_r;
        end
    end

    assign start_ok_s = dirty_r | wr_en;
`else
    assign start_ok_s = 1'b1;
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 6'd0;
            cnt_r   <= '0;
            db_r    <= 10'd0;
            ni_r    <= 1'b0;
            busy_r  <= 1'b0;
            fd_r    <= 1'b0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            cnt_r   <= cnt_n;
            db_r    <= db_n;
            ni_r    <= ni_n;
            busy_r  <= busy_n;
            fd_r    <= fd_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        cnt_n   = cnt_r;
        db_n    = db_r;
        ni_n    = 1'b0;
        busy_n  = busy_r;
        fd_n    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (init_done) begin
                    state_n = ST_ISSUE;
                    idx_n   = 6'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                db_n    = step_word(idx_r, rd_data_s);
                ni_n    = 1'b1;
                busy_n  = 1'b1;
                state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done coincident with our own strobe belongs to nothing we issued.
                if (done && !ni_r) begin
                    if (idx_r == LAST_STEP) begin
                        fd_n    = 1'b1;
                        busy_n  = 1'b0;
                        cnt_n   = '0;
                        state_n = ST_REFRESH;
                    end else begin
                        idx_n   = idx_r + 6'd1;
                        state_n = ST_ISSUE;
                    end
                end else begin
                    state_n = ST_WAIT_DONE;
                end
            end
            ST_REFRESH: begin
                if (cnt_r == REFRESH_LAST) begin
                    if (start_ok_s) begin
                        cnt_n   = '0;
                        idx_n   = 6'd0;
                        state_n = ST_ISSUE;
                    end else begin
                        cnt_n   = cnt_r;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                idx_n   = 6'd0;
                cnt_n   = '0;
            end
        endcase
    end

    assign db               = db_r;
    assign next_instruction = ni_r;
    assign busy             = busy_r;
    assign frame_done       = fd_r;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Scoreboard bench for lcd_frame_sequencer: expected db words are queued ahead of
// each frame and a monitor pops/compares on every next_instruction pulse.
module tb_lcd_frame_sequencer;

    localparam int REFRESH = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_done = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [7:0] wr_data = 8'd0;
    logic       done;
    logic       resp_done = 1'b0;
    logic       spur_done = 1'b0;
    logic [9:0] db;
    logic       next_instruction;
    logic       busy;
    logic       frame_done;

    assign done = resp_done | spur_done;

    lcd_frame_sequencer #(.REFRESH_CYCLES(REFRESH), .CNT_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .init_done        (init_done),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .done             (done),
        .db               (db),
        .next_instruction (next_instruction),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    logic [9:0] exp_q[$];
    logic [7:0] mdl [32];
    int cyc = 0;
    int n_vec = 0, n_err = 0;
    int ni_cnt = 0, ni_in_frame = 0, fd_cnt = 0, fd_cyc = 0;
    bit fd_seen = 1'b0;
    bit gap_chk = 1'b0, wr_chk = 1'b0;
    int wr_cyc = 0;
    int timeouts = 0, exp_ni = 0, exp_fd = 0;
    bit end_req = 1'b0, end_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction-FSM stand-in: done three cycles after every strobe.
    always begin
        @(negedge clk);
        if (next_instruction) begin
            repeat (3) @(negedge clk);
            resp_done = 1'b1;
            @(negedge clk);
            resp_done = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_db", 32'(db), 32'd0);
            chk("reset_ni", 32'(next_instruction), 32'd0);
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_frame_done", 32'(frame_done), 32'd0);
            exp_q.delete();
            ni_in_frame = 0;
            fd_seen = 1'b0;
        end else begin
            if (next_instruction) begin
                if (ni_in_frame == 0 && gap_chk && fd_seen)
                    chk("refresh_gap", 32'(cyc - fd_cyc), 32'(REFRESH + 1));
                if (ni_in_frame == 0 && wr_chk) begin
                    n_vec++;
                    if (cyc - wr_cyc > 2) begin
                        n_err++;
                        $display("FAIL dirty_start_lat: got %0d cycles, want <= 2", cyc - wr_cyc);
                    end
                end
                fd_seen = 1'b0;
                chk("busy_at_ni", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ni: got db 0x%0h, want no strobe", db);
                end else begin
                    chk($sformatf("db_idx%0d", ni_in_frame), 32'(db), 32'(exp_q.pop_front()));
                end
                ni_cnt++;
                ni_in_frame++;
            end
            if (frame_done) begin
                chk("frame_len", 32'(ni_in_frame), 32'd34);
                chk("busy_after_frame", 32'(busy), 32'd0);
                fd_cnt++;
                fd_cyc = cyc;
                fd_seen = 1'b1;
                ni_in_frame = 0;
            end
        end
        if (end_req && !end_done) begin
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            chk("ni_total", 32'(ni_cnt), 32'(exp_ni));
            chk("frame_done_total", 32'(fd_cnt), 32'(exp_fd));
            chk("wait_timeouts", 32'(timeouts), 32'd0);
            end_done = 1'b1;
        end
    end

    task automatic push_frame();
        exp_q.push_back(10'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({2'b10, mdl[i]});
        exp_q.push_back(10'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back({2'b10, mdl[i]});
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_cyc = cyc;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic spurious();
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
    endtask

    task automatic wait_fd(input int n);
        int k = 0;
        while (fd_cnt < n && k < 5000) begin @(negedge clk); #1; k++; end
        if (fd_cnt < n) timeouts++;
    endtask

    task automatic wait_ni(input int n);
        int k = 0;
        while (ni_in_frame < n && k < 5000) begin @(negedge clk); #1; k++; end
        if (ni_in_frame < n) timeouts++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        repeat (3) @(negedge clk);
        reset = 1'b0;
`ifdef LCD_FRAME_DIRTY_EN
        push_frame();
        init_done = 1'b1;
        wait_fd(1);
        repeat (5 * REFRESH) @(negedge clk);
        mdl[0] = 8'h41;
        push_frame();
        wr_chk = 1'b1;
        wr(5'd0, 8'h41);
        wait_fd(2);
        exp_ni = 68;
        exp_fd = 2;
`else
        wr(5'd0, 8'h48); wr(5'd1, 8'h45); wr(5'd2, 8'h4C); wr(5'd3, 8'h4C); wr(5'd4, 8'h4F);
        wr(5'd31, 8'h5A);
        mdl[0] = 8'h48; mdl[1] = 8'h45; mdl[2] = 8'h4C; mdl[3] = 8'h4C; mdl[4] = 8'h4F;
        mdl[31] = 8'h5A;
        spurious();
        repeat (5) @(negedge clk);
        push_frame();
        mdl[20] = 8'h41;
        push_frame();
        mdl[2] = 8'h42;
        push_frame();
        push_frame();
        gap_chk = 1'b1;
        init_done = 1'b1;
        wait_fd(1);
        wait_ni(11);
        wr(5'd20, 8'h41);
        wr(5'd2, 8'h42);
        wait_fd(3);
        repeat (20) @(negedge clk);
        spurious();
        wait_ni(13);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        reset = 1'b0;
        #1;
        push_frame();
        wait_fd(4);
        exp_ni = 3 * 34 + 13 + 34;
        exp_fd = 4;
`endif
        end_req = 1'b1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
